core_writeback: RTL and testbench

Writeback arbiter and load scoreboard directly upstream of the integer register file. It merges single-cycle ALU results and in-order load responses from the LSU onto the register file's single write port (address, data, write-enable). It buffers ALU results while a load owns the port and tracks destinations of outstanding loads so issue logic can stall on RAW/WAW hazards.

---
 rtl/core_writeback.sv | 192 +++++++++++++++++++
 tb/tb_core_writeback.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/core_writeback.sv
// core_writeback: arbitrates ALU results and in-order load responses onto the
// single register-file write port and tracks destinations of outstanding loads
// so issue logic can stall on hazards against them.
module core_writeback #(
    parameter int XLEN           = 32,
    parameter int NUMREGS        = 32,
    parameter int ALU_FIFO_DEPTH = 2,
    parameter int LDQ_DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [4:0]         alu_rd,
    input  logic [XLEN-1:0]    alu_data,
    input  logic               ld_issue,
    output logic               ld_issue_ready,
    input  logic [4:0]         ld_issue_rd,
    input  logic               ld_valid,
    input  logic [XLEN-1:0]    ld_data,
    output logic [4:0]         rf_a2,
    output logic [XLEN-1:0]    rf_wd2,
    output logic               rf_we2,
    output logic [NUMREGS-1:0] busy,
    output logic               protocol_err
);
    localparam int AAW = $clog2(ALU_FIFO_DEPTH);
    localparam int LAW = $clog2(LDQ_DEPTH);
    localparam logic [AAW:0] AF_ONE = {{AAW{1'b0}}, 1'b1};
    localparam logic [LAW:0] TQ_ONE = {{LAW{1'b0}}, 1'b1};

    // ALU result buffer: pointers carry one extra wrap bit
    logic [4:0]      af_rd_r   [ALU_FIFO_DEPTH];
    logic [XLEN-1:0] af_data_r [ALU_FIFO_DEPTH];
    logic [AAW:0]    af_wp_r;
    logic [AAW:0]    af_rp_r;
    logic            af_full_s;
    logic            af_empty_s;
    logic            af_push_s;
    logic            af_pop_s;

    // Load tag queue: destinations of loads still awaiting their response
    logic [4:0]      tq_rd_r [LDQ_DEPTH];
    logic [LAW:0]    tq_wp_r;
    logic [LAW:0]    tq_rp_r;
    logic            tq_full_s;
    logic            tq_empty_s;
    logic            tq_push_s;
    logic            tq_pop_s;
    logic [LAW:0]    tq_count_s;
    logic [LAW-1:0]  tq_idx_s;

    // Write-port selection
    logic            alu_acc_s;
    logic            sel_valid_s;
    logic            sel_ld_s;
    logic [4:0]      sel_rd_s;
    logic [XLEN-1:0] sel_data_s;
    logic            out_ld_r;
    logic            err_set_s;
    logic [NUMREGS-1:0] busy_s;

    assign af_empty_s = (af_wp_r == af_rp_r);
    assign af_full_s  = (af_wp_r[AAW] != af_rp_r[AAW]) &&
                        (af_wp_r[AAW-1:0] == af_rp_r[AAW-1:0]);
    assign tq_empty_s = (tq_wp_r == tq_rp_r);
    assign tq_full_s  = (tq_wp_r[LAW] != tq_rp_r[LAW]) &&
                        (tq_wp_r[LAW-1:0] == tq_rp_r[LAW-1:0]);

    // Ready flags depend on stored state only, never on the offered inputs
    assign alu_ready      = !af_full_s;
    assign ld_issue_ready = !tq_full_s;

    assign alu_acc_s = alu_valid && !af_full_s;
    assign tq_push_s = ld_issue && !tq_full_s;
    assign tq_pop_s  = ld_valid && !tq_empty_s;
    assign err_set_s = (ld_valid && tq_empty_s) || (ld_issue && tq_full_s);

    // Priority select: load response, then buffered ALU head, then ALU bypass
    always_comb begin
        sel_valid_s = 1'b0;
        sel_ld_s    = 1'b0;
        sel_rd_s    = 5'd0;
        sel_data_s  = {XLEN{1'b0}};
        af_pop_s    = 1'b0;
        af_push_s   = 1'b0;
        if (tq_pop_s) begin
            sel_valid_s = 1'b1;
            sel_ld_s    = 1'b1;
            sel_rd_s    = tq_rd_r[tq_rp_r[LAW-1:0]];
            sel_data_s  = ld_data;
            af_push_s   = alu_acc_s;
        end else if (!af_empty_s) begin
            sel_valid_s = 1'b1;
            sel_rd_s    = af_rd_r[af_rp_r[AAW-1:0]];
            sel_data_s  = af_data_r[af_rp_r[AAW-1:0]];
            af_pop_s    = 1'b1;
            af_push_s   = alu_acc_s;
        end else if (alu_acc_s) begin
            sel_valid_s = 1'b1;
            sel_rd_s    = alu_rd;
            sel_data_s  = alu_data;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // Busy mask: every queued load destination plus a load write still in the output register
    always_comb begin
        busy_s     = {NUMREGS{1'b0}};
        tq_idx_s   = {LAW{1'b0}};
        tq_count_s = tq_wp_r - tq_rp_r;
        for (int k = 0; k < LDQ_DEPTH; k++) begin
            tq_idx_s = tq_rp_r[LAW-1:0] + k[LAW-1:0];
            for (int r = 1; r < NUMREGS; r++) begin
                busy_s[r] = busy_s[r] |
                            (({1'b0, k[LAW-1:0]} < tq_count_s) && (tq_rd_r[tq_idx_s] == r[4:0]));
            end
        end
        for (int r = 1; r < NUMREGS; r++) begin
            busy_s[r] = busy_s[r] | (out_ld_r && rf_we2 && (rf_a2 == r[4:0]));
        end
    end

    assign busy = busy_s;

    // ALU result buffer storage and pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            af_wp_r <= {(AAW+1){1'b0}};
            af_rp_r <= {(AAW+1){1'b0}};
            for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
                af_rd_r[i]   <= 5'd0;
                af_data_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            if (af_push_s) begin
                af_rd_r[af_wp_r[AAW-1:0]]   <= alu_rd;
                af_data_r[af_wp_r[AAW-1:0]] <= alu_data;
                af_wp_r <= af_wp_r + AF_ONE;
            end
            if (af_pop_s) begin
                af_rp_r <= af_rp_r + AF_ONE;
            end
        end
    end

    // Load tag queue storage and pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tq_wp_r <= {(LAW+1){1'b0}};
            tq_rp_r <= {(LAW+1){1'b0}};
            for (int i = 0; i < LDQ_DEPTH; i++) begin
                tq_rd_r[i] <= 5'd0;
            end
        end else begin
            if (tq_push_s) begin
                tq_rd_r[tq_wp_r[LAW-1:0]] <= ld_issue_rd;
                tq_wp_r <= tq_wp_r + TQ_ONE;
            end
            if (tq_pop_s) begin
                tq_rp_r <= tq_rp_r + TQ_ONE;
            end
        end
    end

    // Registered write port; x0 destinations are consumed but never enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we2   <= 1'b0;
            rf_a2    <= 5'd0;
            rf_wd2   <= {XLEN{1'b0}};
            out_ld_r <= 1'b0;
        end else begin
            rf_we2   <= sel_valid_s && (sel_rd_s != 5'd0);
            out_ld_r <= sel_ld_s;
            if (sel_valid_s) begin
                rf_a2  <= sel_rd_s;
                rf_wd2 <= sel_data_s;
            end
        end
    end

    // Sticky protocol error flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            protocol_err <= 1'b0;
        end else if (err_set_s) begin
            protocol_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_core_writeback.sv
// Directed table-driven bench for core_writeback.
module tb_core_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic        ld_issue_ready;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  rf_a2;
    logic [31:0] rf_wd2;
    logic        rf_we2;
    logic [31:0] busy;
    logic        protocol_err;

    int checks = 0;
    int errors = 0;

    core_writeback #(.XLEN(32), .NUMREGS(32), .ALU_FIFO_DEPTH(2), .LDQ_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_ready(ld_issue_ready), .ld_issue_rd(ld_issue_rd),
        .ld_valid(ld_valid), .ld_data(ld_data),
        .rf_a2(rf_a2), .rf_wd2(rf_wd2), .rf_we2(rf_we2),
        .busy(busy), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pre_rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        li;
        logic [4:0]  lird;
        logic        lv;
        logic [31:0] ldata;
        logic        we;
        logic [4:0]  a2;
        logic [31:0] wd;
        logic [31:0] bz;
        logic        ar;
        logic        lir;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    vec_t tail[$];

    function automatic vec_t mk(logic pr, logic av, logic [4:0] ard, logic [31:0] adata,
                                logic li, logic [4:0] lird, logic lv, logic [31:0] ldata,
                                logic we, logic [4:0] a2, logic [31:0] wd, logic [31:0] bz,
                                logic ar, logic lir, logic err);
        vec_t v;
        v.pre_rst = pr; v.av = av; v.ard = ard; v.adata = adata;
        v.li = li; v.lird = lird; v.lv = lv; v.ldata = ldata;
        v.we = we; v.a2 = a2; v.wd = wd; v.bz = bz; v.ar = ar; v.lir = lir; v.err = err;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_issue = 1'b0; ld_issue_rd = 5'd0; ld_valid = 1'b0; ld_data = 32'd0;
    endtask

    task automatic apply(vec_t v, string tag);
        if (v.pre_rst) begin
            idle_inputs();
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.adata;
        ld_issue = v.li; ld_issue_rd = v.lird; ld_valid = v.lv; ld_data = v.ldata;
        @(posedge clk); #1;
        chk({tag, " rf_we2"}, {31'd0, rf_we2}, {31'd0, v.we});
        if (v.we) begin
            chk({tag, " rf_a2"}, {27'd0, rf_a2}, {27'd0, v.a2});
            chk({tag, " rf_wd2"}, rf_wd2, v.wd);
        end
        chk({tag, " busy"}, busy, v.bz);
        chk({tag, " alu_ready"}, {31'd0, alu_ready}, {31'd0, v.ar});
        chk({tag, " ld_issue_ready"}, {31'd0, ld_issue_ready}, {31'd0, v.lir});
        chk({tag, " protocol_err"}, {31'd0, protocol_err}, {31'd0, v.err});
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // ALU bypass
        vecs.push_back(mk(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 32'd0, 1, 5'd5, 32'hDEADBEEF, 32'h0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 0, 32'd0, 0, 5'd0, 32'd0, 32'h0, 1, 1, 0));
        // Single load to x7 with three idle cycles
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 1, 5'd7, 0, 32'd0, 0, 5'd0, 32'd0, 32'h80, 1, 1, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 0, 32'd0, 0, 5'd0, 32'd0, 32'h80, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 32'h12345678, 1, 5'd7, 32'h12345678, 32'h80, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 0, 32'd0, 0, 5'd0, 32'd0, 32'h0, 1, 1, 0));
        // Three loads outstanding, responses compete with ALU rd 1,2,3
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 1, 5'd10, 0, 32'd0, 0, 5'd0, 32'd0, 32'h400, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 1, 5'd11, 0, 32'd0, 0, 5'd0, 32'd0, 32'hC00, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 1, 5'd12, 0, 32'd0, 0, 5'd0, 32'd0, 32'h1C00, 1, 1, 0));
        vecs.push_back(mk(0, 1, 5'd1, 32'h11111111, 0, 5'd0, 1, 32'hA0A0A0A0, 1, 5'd10, 32'hA0A0A0A0, 32'h1C00, 1, 1, 0));
        vecs.push_back(mk(0, 1, 5'd2, 32'h22222222, 0, 5'd0, 1, 32'hB0B0B0B0, 1, 5'd11, 32'hB0B0B0B0, 32'h1800, 0, 1, 0));
        vecs.push_back(mk(0, 1, 5'd3, 32'h33333333, 0, 5'd0, 1, 32'hC0C0C0C0, 1, 5'd12, 32'hC0C0C0C0, 32'h1000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 5'd3, 32'h33333333, 0, 5'd0, 0, 32'd0, 1, 5'd1, 32'h11111111, 32'h0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 5'd3, 32'h33333333, 0, 5'd0, 0, 32'd0, 1, 5'd2, 32'h22222222, 32'h0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 0, 32'd0, 1, 5'd3, 32'h33333333, 32'h0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 0, 32'd0, 0, 5'd0, 32'd0, 32'h0, 1, 1, 0));
        // Fill the tag queue, overflow issue, drain in order
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 1, 5'd1, 0, 32'd0, 0, 5'd0, 32'd0, 32'h2, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 1, 5'd2, 0, 32'd0, 0, 5'd0, 32'd0, 32'h6, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 1, 5'd3, 0, 32'd0, 0, 5'd0, 32'd0, 32'hE, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 1, 5'd4, 0, 32'd0, 0, 5'd0, 32'd0, 32'h1E, 1, 0, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 1, 5'd9, 0, 32'd0, 0, 5'd0, 32'd0, 32'h1E, 1, 0, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 32'h00000001, 1, 5'd1, 32'h00000001, 32'h1E, 1, 1, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 32'h00000002, 1, 5'd2, 32'h00000002, 32'h1C, 1, 1, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 32'h00000003, 1, 5'd3, 32'h00000003, 32'h18, 1, 1, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 32'h00000004, 1, 5'd4, 32'h00000004, 32'h10, 1, 1, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 0, 32'd0, 0, 5'd0, 32'd0, 32'h0, 1, 1, 1));
        // After reset: x0 writes from both sources, then response on empty queue
        vecs.push_back(mk(1, 1, 5'd0, 32'h55555555, 0, 5'd0, 0, 32'd0, 0, 5'd0, 32'd0, 32'h0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 1, 5'd0, 0, 32'd0, 0, 5'd0, 32'd0, 32'h0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 32'h66666666, 0, 5'd0, 32'd0, 32'h0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 0, 32'd0, 0, 5'd0, 32'd0, 32'h0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 32'h77777777, 0, 5'd0, 32'd0, 32'h0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 0, 32'd0, 0, 5'd0, 32'd0, 32'h0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 5'd13, 32'h0D0D0D0D, 0, 5'd0, 0, 32'd0, 1, 5'd13, 32'h0D0D0D0D, 32'h0, 1, 1, 1));
        // Build up: full ALU buffer plus two outstanding loads (10, 11)
        vecs.push_back(mk(1, 0, 5'd0, 32'd0, 1, 5'd8, 0, 32'd0, 0, 5'd0, 32'd0, 32'h100, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 1, 5'd9, 0, 32'd0, 0, 5'd0, 32'd0, 32'h300, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 1, 5'd10, 0, 32'd0, 0, 5'd0, 32'd0, 32'h700, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'd0, 32'd0, 1, 5'd11, 0, 32'd0, 0, 5'd0, 32'd0, 32'hF00, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5'd20, 32'h14141414, 0, 5'd0, 1, 32'h88888888, 1, 5'd8, 32'h88888888, 32'hF00, 1, 1, 0));
        vecs.push_back(mk(0, 1, 5'd21, 32'h15151515, 0, 5'd0, 1, 32'h99999999, 1, 5'd9, 32'h99999999, 32'hE00, 0, 1, 0));

        // After the mid-operation reset: fresh bypass, nothing stale drains, tags gone
        tail.push_back(mk(0, 1, 5'd6, 32'hCAFEF00D, 0, 5'd0, 0, 32'd0, 1, 5'd6, 32'hCAFEF00D, 32'h0, 1, 1, 0));
        tail.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 0, 32'd0, 0, 5'd0, 32'd0, 32'h0, 1, 1, 0));
        tail.push_back(mk(0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 32'h00000001, 0, 5'd0, 32'd0, 32'h0, 1, 1, 1));

        // Reset values
        @(posedge clk); @(posedge clk); #1;
        chk("reset rf_we2", {31'd0, rf_we2}, 32'd0);
        chk("reset rf_a2", {27'd0, rf_a2}, 32'd0);
        chk("reset rf_wd2", rf_wd2, 32'd0);
        chk("reset busy", busy, 32'd0);
        chk("reset protocol_err", {31'd0, protocol_err}, 32'd0);
        chk("reset alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("reset ld_issue_ready", {31'd0, ld_issue_ready}, 32'd1);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Asynchronous reset with a pending write, full buffer and outstanding tags
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("async rst rf_we2", {31'd0, rf_we2}, 32'd0);
        chk("async rst busy", busy, 32'd0);
        chk("async rst alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("async rst ld_issue_ready", {31'd0, ld_issue_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < tail.size(); i++) begin
            apply(tail[i], $sformatf("t%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
